cacheline_adaptor: RTL
======================

# cacheline_adaptor

Responder for the cache's 256-bit physical-memory line interface. It converts each line read or line write into a burst of fixed-width beats on the burst-memory bus and returns a single-cycle `pmem_resp` when the whole line has transferred. It sits between the cache's `pmem_*` port and the burst-capable main memory model/controller.

## Interface
- `BEAT_W`, default 64: beat width in bits. Legal values are 32, 64 and 128. `BEATS = 256/BEAT_W`. The beat counter is `$clog2(BEATS)` bits wide.
- `clk` input 1: single clock. All state changes on its rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `pmem_read` input 1: line read request from the cache.
- `pmem_write` input 1: line write request from the cache.
- `pmem_address` input 32: line address. Bits [4:0] are ignored.
- `pmem_wdata` input 256: line to write.
- `pmem_rdata` output 256: assembled read line.
- `pmem_resp` output 1: one-cycle completion pulse.
- `bmem_address` output 32: burst address, always `{pmem_address[31:5], 5'b0}`.
- `bmem_read` output 1: burst read active.
- `bmem_write` output 1: burst write active.
- `bmem_wdata` output BEAT_W: current write beat.
- `bmem_rdata` input BEAT_W: current read beat.
- `bmem_resp` input 1: beat accepted (write) or beat valid (read).

## Operation
- States: IDLE, READ, WRITE, DONE. Reset state is IDLE.
- Outputs on reset:
  - `pmem_resp=0`, `bmem_read=0`, `bmem_write=0`, `bmem_address=0`, `bmem_wdata=0`, `pmem_rdata=0`.
  - Beat counter = 0.
- IDLE:
  - If `pmem_write` is high: latch the address and `pmem_wdata`, clear the counter, go to WRITE.
  - Else if `pmem_read` is high: latch the address, clear the counter, go to READ.
  - If both are high, the write wins. The read is serviced afterwards only if still requested.
- READ:
  - `bmem_read=1`.
  - Each cycle with `bmem_resp=1`: store `bmem_rdata` into line slice `[cnt*BEAT_W +: BEAT_W]` and increment `cnt`.
  - The beat taken at `cnt==BEATS-1` moves the block to DONE.
- WRITE:
  - `bmem_write=1`, `bmem_wdata` = latched line slice `[cnt*BEAT_W +: BEAT_W]`.
  - Each `bmem_resp=1` increments `cnt`.
  - The last beat moves the block to DONE.
- DONE: `pmem_resp=1` for exactly one cycle, then return to IDLE.
- Beat order is ascending: beat 0 carries bits [BEAT_W-1:0].
- Beats may arrive with gaps. Cycles with `bmem_resp=0` hold `cnt` and the outputs unchanged.
- `bmem_resp` is ignored in IDLE and DONE.
- `pmem_rdata` holds the last completed read line until the next read completes. It is never partially updated as seen by the cache: the update is committed at the READ->DONE transition, from a separate assembly buffer.
- `pmem_address`, `pmem_wdata` and the request lines may change after the IDLE sample. The latched copies are used.

## Timing
- All outputs are registered or decoded purely from state and registers. There is no combinational path from `pmem_*` to `bmem_*`.
- Request sampled in IDLE at edge N:
  - `bmem_read`/`bmem_write` high from cycle N+1.
  - The first beat can be accepted at edge N+1.
- With back-to-back beats, the last beat is accepted at edge N+BEATS.
  - `pmem_resp` is high during cycle N+BEATS+1.
  - Minimum request-to-resp latency is BEATS+1 cycles (5 for the default).
- `bmem_read`/`bmem_write` drop in the DONE cycle, i.e. the cycle after the last `bmem_resp`.
- Handshake contract with the cache:
  - The cache holds its request until it sees `pmem_resp`.
  - The cache deasserts the request on the edge that samples `pmem_resp`.
  - The adaptor is in IDLE the cycle after DONE. A request still high then starts a new transaction.
- `rst` asserted mid-burst: the block goes to IDLE immediately (asynchronously), drops `bmem_read`/`bmem_write`, and discards partial data. No `pmem_resp` is issued for the aborted transaction.

## Test plan
- Read, default parameter:
  - Stimulus: `pmem_read` with `pmem_address=0x1234_567F`; memory returns beats 0x00..00, 0x11..11, 0x22..22, 0x33..33 back to back.
  - Required: `bmem_address=0x1234_5660`; `pmem_resp` in cycle 5; `pmem_rdata=0x33..33_22..22_11..11_00..00`.
- Write:
  - Stimulus: `pmem_wdata=0xDDDD..._CCCC..._BBBB..._AAAA...`.
  - Required: `bmem_wdata` sequence 0xAAAA.., 0xBBBB.., 0xCCCC.., 0xDDDD..; `bmem_write` high for exactly the 4 beat cycles; one `pmem_resp` pulse.
- Gapped beats:
  - Stimulus: `bmem_resp` pattern 1,0,0,1,0,1,1.
  - Required: data lands in the correct slices; `pmem_resp` exactly one cycle after the 4th resp; stale `bmem_rdata` during gaps is not captured.
- Simultaneous request:
  - Stimulus: `pmem_read` and `pmem_write` high together.
  - Required: write burst first; `pmem_rdata` unchanged until a later read completes.
- Reset mid-read:
  - Stimulus: assert `rst` after 2 beats, then run a fresh read.
  - Required: outputs go to 0 immediately; no `pmem_resp`; the new read assembles all 4 new beats with no leftover data.
- Parameter sweep:
  - Stimulus: BEAT_W=32 and BEAT_W=128.
  - Required: 8 and 2 beats respectively; latencies of 9 and 3 cycles.

Source files
------------

// File: rtl/cacheline_adaptor.sv
// Bridges the cache's 256-bit line port to a narrow burst-memory bus.
// A line read or write becomes 256/BEAT_W ascending beats, then one pmem_resp pulse.
module cacheline_adaptor #(
    parameter int BEAT_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pmem_read,
    input  logic              pmem_write,
    input  logic [31:0]       pmem_address,
    input  logic [255:0]      pmem_wdata,
    output logic [255:0]      pmem_rdata,
    output logic              pmem_resp,
    output logic [31:0]       bmem_address,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [BEAT_W-1:0] bmem_wdata,
    input  logic [BEAT_W-1:0] bmem_rdata,
    input  logic              bmem_resp
);
    localparam int BEATS = 256 / BEAT_W;
    localparam int CW    = $clog2(BEATS);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t                         r_state, w_next;
    logic [CW-1:0]                  r_cnt;
    logic [26:0]                    r_line_addr;
    logic [BEATS-1:0][BEAT_W-1:0]   r_wline, r_abuf, r_rdata, w_asm;
    logic                           w_last;
    logic                           w_unused;

    assign w_last   = (r_cnt == CW'(BEATS - 1));
    assign w_unused = ^pmem_address[4:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (pmem_write)     w_next = WRITE;
                else if (pmem_read) w_next = READ;
            end
            READ:    if (bmem_resp && w_last) w_next = DONE;
            WRITE:   if (bmem_resp && w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Current beat merged into the assembly buffer; also the committed line on the last beat.
    always_comb begin
        w_asm        = r_abuf;
        w_asm[r_cnt] = bmem_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_line_addr <= '0;
            r_wline     <= '0;
            r_abuf      <= '0;
            r_rdata     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (pmem_write || pmem_read) begin
                        r_line_addr <= pmem_address[31:5];
                        r_cnt       <= '0;
                    end
                    if (pmem_write) r_wline <= pmem_wdata;
                end
                READ: begin
                    if (bmem_resp) begin
                        r_abuf <= w_asm;
                        r_cnt  <= r_cnt + 1'b1;
                        if (w_last) r_rdata <= w_asm;
                    end
                end
                WRITE: begin
                    if (bmem_resp) r_cnt <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign pmem_rdata   = r_rdata;
    assign pmem_resp    = (r_state == DONE);
    assign bmem_read    = (r_state == READ);
    assign bmem_write   = (r_state == WRITE);
    assign bmem_address = {r_line_addr, 5'b0};
    assign bmem_wdata   = r_wline[r_cnt];
endmodule
